// File: rtl/addsub_pkg.sv
// addsub_pkg: state encoding, default width and counter sizing shared by serial_addsub
package addsub_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int DEF_WIDTH = 4;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/full_adder.sv
// Full_Adder: single-bit full adder cell
module Full_Adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/sub over one Full_Adder, LSB first; ovf port with SERIAL_ADDSUB_OVF_EN
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = cnt_w(WIDTH);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d, breg_q, breg_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic fa_sum, fa_cout, last;
  Full_Adder u_fa (
    .A(areg_q[0]),
    .B(breg_q[0]),
    .Cin(carry_q),
    .Sum(fa_sum),
    .Cout(fa_cout)
  );
  assign last = cnt_q == CW'(WIDTH - 1);
  assign in_ready = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign sum = res_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic cmsb_q, cmsb_d;
  assign ovf = cmsb_q ^ cout_q;
`endif
  always_comb begin
    state_d = state_q;
    areg_d = areg_q;
    breg_d = breg_q;
    res_d = res_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    cout_d = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    cmsb_d = cmsb_q;
`endif
    if (state_q == ST_IDLE && in_valid) begin
      state_d = ST_SHIFT;
      areg_d = a;
      breg_d = sub ? ~b : b;
      carry_d = sub;
      cnt_d = '0;
      res_d = '0;
      cout_d = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      cmsb_d = 1'b0;
`endif
    end else if (state_q == ST_SHIFT) begin
      res_d = {fa_sum, res_q[WIDTH-1:1]};
      areg_d = areg_q >> 1;
      breg_d = breg_q >> 1;
      carry_d = fa_cout;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = ST_DONE;
        cout_d = fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
        cmsb_d = carry_q;
`endif
      end
    end else if (state_q == ST_DONE && out_ready) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      areg_q <= '0;
      breg_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      cmsb_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      areg_q <= areg_d;
      breg_q <= breg_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      cmsb_q <= cmsb_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors for serial_addsub (WIDTH=4)
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst, in_valid, sub, out_ready;
  logic in_ready, out_valid, cout;
  logic [3:0] a, b, sum;
  int n_checks = 0;
  int n_fail = 0;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf;
`endif
  serial_addsub #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic vs, input logic [3:0] e_sum, input logic e_cout,
                       input logic e_ovf, input int hold, input bit noise);
    int lat;
    logic [3:0] held;
    a = va;
    b = vb;
    sub = vs;
    in_valid = 1'b1;
    step();
    lat = 1;
    in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && lat < 50) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a = 4'($urandom);
        b = 4'($urandom);
        sub = 1'($urandom);
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_sum"}, 32'(sum), 32'(e_sum));
    check({tag, "_cout"}, 32'(cout), 32'(e_cout));
`ifdef SERIAL_ADDSUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
`else
    if (e_ovf) n_checks += 0;
`endif
    held = sum;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_bp_sum"}, 32'(sum), 32'(held));
      check({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_handoff_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_retain_sum"}, 32'(sum), 32'(e_sum));
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    do_op("5p3", 4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b1, 0, 1'b0);
    do_op("7m2", 4'd7, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0, 3, 1'b0);
    do_op("2m7", 4'd2, 4'd7, 1'b1, 4'hB, 1'b0, 1'b0, 0, 1'b1);
    do_op("Fp1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 0, 1'b0);
    do_op("8m1", 4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1, 0, 1'b1);
    a = 4'd6;
    b = 4'd1;
    sub = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    do_op("4p4", 4'd4, 4'd4, 1'b0, 4'd8, 1'b0, 1'b1, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial add/subtract unit. It accepts a WIDTH-bit operand pair and a sub flag through a valid/ready handshake, then drives one Full_Adder stage for one bit per cycle, LSB first. It captures that stage's Sum/Cout into a shift register and carry flop, and presents the result through an output valid/ready handshake. It is the area-reduced alternative to the ripple 4-bit add/sub, and sits directly around the full-adder cell as both its operand feeder and its result consumer.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend/addend
- b  input  WIDTH  subtrahend/addend
- sub  input  1  1 = a−b, 0 = a+b
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out; for sub, 1 = no borrow (a ≥ b unsigned)
- ovf  output  1  signed overflow (present only with SERIAL_ADDSUB_OVF_EN)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load areg=a, breg = sub ? ~b : b, carry=sub, cnt=0, clear result reg; go to SHIFT.
- SHIFT:
  - Full_Adder inputs are A=areg[0], B=breg[0], Cin=carry.
  - Each cycle: result <= {Sum, result[WIDTH-1:1]}; areg/breg shift right; carry <= Cout; cnt++.
  - When cnt==WIDTH-1, the current bit is the last; record the carry into the MSB (for ovf) and go to DONE.
  - in_valid is ignored in this state.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready: go to IDLE.
- Arithmetic: two's complement via inverted b plus carry-in of 1. sum is always truncated to WIDTH bits; cout is the final carry.
- Inputs are sampled only on the accept edge; changes afterwards have no effect.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, sum=0, cout=0, ovf=0, cnt=0.
- Accept at edge t. out_valid rises after edge t+WIDTH, i.e. WIDTH+1 cycles from accept.
- Minimum op period: WIDTH+2 cycles, because no accept happens in the same cycle as a result handoff.
- out_valid && out_ready at edge e: state is IDLE after e, with out_valid=0 and in_ready=1. sum/cout/ovf retain the last value until the next accept clears them.
- Backpressure: out_ready low holds DONE indefinitely; outputs must not change.
- rst during SHIFT or DONE: the result is discarded and all outputs take their reset values on the next edge. No partial result is ever flagged valid.
- rst has priority over in_valid and out_ready in the same cycle.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - ovf port exists; ovf = carry into MSB XOR carry out of MSB.
  - ovf is registered with the result and valid while out_valid=1.
- Undefined: no ovf port, no MSB carry-in flop; all other behaviour is identical.

## Structure
- Shared package addsub_pkg:
  - state encoding constants (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2)
  - default WIDTH constant
  - counter width derived as clog2(WIDTH)
- One sub-module: a single instance of the existing Full_Adder cell. All sequencing, shifting and handshake logic is in serial_addsub.

## Test plan
- 5+3, sub=0 -> sum=8, cout=0, ovf=1; out_valid rises exactly 5 cycles after accept.
- 7−2, sub=1 -> sum=5, cout=1, ovf=0.
- 2−7, sub=1 -> sum=0xB, cout=0, ovf=0.
- 0xF+0x1 -> sum=0x0, cout=1, ovf=0; then 0x8−0x1 -> sum=0x7, cout=1, ovf=1.
- Backpressure and ignored input:
  - Hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, sum is stable, in_ready stays 0.
  - Toggle in_valid and a/b during SHIFT -> the result is unaffected.
- Reset mid-operation:
  - Assert rst on the 2nd SHIFT cycle -> next cycle out_valid=0, in_ready=1, sum=0.
  - A following 4+4 -> sum=8, cout=0.
